// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu : registered WIDTH-bit ALU with valid/ready handshakes on both
// sides, status flags, shifts and an optional iterative shift-add multiplier.
//
// Build option:
//   SEQ_ALU_MUL_EN  defined   -> opcode 12 is a multi-cycle a*b (EXEC state)
//                   undefined -> opcode 12 behaves like 13..15 (result 0)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands/opcode present
//   in_ready   block can accept (transfer on in_valid & in_ready)
//   a, b       WIDTH-bit operands (b is also the shift amount)
//   sel        4-bit opcode
//   out_valid  result and flags valid
//   out_ready  consumer accepts (transfer on out_valid & out_ready)
//   result     registered result
//   carry, zero, negative, overflow  registered flags
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOTA = 4'd3;
    localparam logic [3:0] OP_NOTB = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_PASA = 4'd7;
    localparam logic [3:0] OP_PASB = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;

`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1,
        EXEC = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1
    } state_t;
`endif

    state_t state_reg;

    // ---------------------------------------------------------------------
    // Single-cycle datapath (combinational from the live inputs; its outputs
    // are only registered on an accepting edge)
    // ---------------------------------------------------------------------
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    dif_ext;
    logic [SH_W-1:0]   shamt;
    logic              shift_big;
    logic [WIDTH-1:0]  sra_val;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry;
    logic              alu_ovf;

    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        dif_ext   = {1'b0, a} - {1'b0, b};
        shamt     = b[SH_W-1:0];
        // WIDTH is a power of two, so b >= WIDTH exactly when any bit above
        // the in-range shift amount is set.
        shift_big = |b[WIDTH-1:SH_W];
        // Kept in its own statement so the shift stays signed (a ternary with
        // an unsigned arm would turn >>> into a logical shift).
        sra_val   = $signed(a) >>> shamt;

        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (sel)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOTA: alu_res = ~a;
            OP_NOTB: alu_res = ~b;
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow (a < b).
                alu_res   = dif_ext[WIDTH-1:0];
                alu_carry = dif_ext[WIDTH];
                alu_ovf   = (a[MSB] != b[MSB]) && (dif_ext[MSB] != a[MSB]);
            end
            OP_PASA: alu_res = a;
            OP_PASB: alu_res = b;
            OP_SHL:  alu_res = shift_big ? '0 : (a << shamt);
            OP_SHR:  alu_res = shift_big ? '0 : (a >> shamt);
            OP_SRA:  alu_res = shift_big ? {WIDTH{a[MSB]}} : sra_val;
            default: alu_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    // ---------------------------------------------------------------------
    // Shift-add multiplier. prod_reg = {high half, multiplier/low half}.
    // Count 0 is the load cycle; counts 1..WIDTH are the add-shift steps.
    // ---------------------------------------------------------------------
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);

    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] prod_step;

    always_comb begin
        psum      = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                  + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
        // {psum, low half} shifted right by one, dropping the consumed bit.
        prod_step = {psum, prod_reg[WIDTH-1:1]};
    end
`endif

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic accept;

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE:    in_ready = 1'b1;
                DONE:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & in_ready;

    // ---------------------------------------------------------------------
    // FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            out_valid  <= 1'b0;
            result     <= '0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            negative   <= 1'b0;
            overflow   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            cnt_reg    <= '0;
            prod_reg   <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
`endif
        end else begin
`ifdef SEQ_ALU_MUL_EN
            if (state_reg == EXEC) begin
                if (cnt_reg == '0) begin
                    prod_reg <= {{WIDTH{1'b0}}, mplier_reg};
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                end else begin
                    prod_reg <= prod_step;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= DONE;
                        out_valid <= 1'b1;
                        result    <= prod_step[WIDTH-1:0];
                        carry     <= |prod_step[2*WIDTH-1:WIDTH];
                        overflow  <= |prod_step[2*WIDTH-1:WIDTH];
                        zero      <= (prod_step[WIDTH-1:0] == '0);
                        negative  <= prod_step[MSB];
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                    end
                end
            end else
`endif
            if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                if (sel == OP_MUL) begin
                    state_reg  <= EXEC;
                    out_valid  <= 1'b0;
                    mcand_reg  <= a;
                    mplier_reg <= b;
                    cnt_reg    <= '0;
                end else
`endif
                begin
                    state_reg <= DONE;
                    out_valid <= 1'b1;
                    result    <= alu_res;
                    carry     <= alu_carry;
                    zero      <= (alu_res == '0);
                    negative  <= alu_res[MSB];
                    overflow  <= alu_ovf;
                end
            end else if ((state_reg == DONE) && out_ready) begin
                // Output drained with nothing new behind it.
                state_reg <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
